// File: rtl/cpu_pkg.sv
// Shared CPU definitions: JumpOP encodings, fetch FSM states and PC constants.
package cpu_pkg;

    localparam logic [1:0] JOP_SEQ = 2'b00;
    localparam logic [1:0] JOP_BR  = 2'b01;
    localparam logic [1:0] JOP_JR  = 2'b10;
    localparam logic [1:0] JOP_J   = 2'b11;

    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_FAULT_PC = 32'h0000_0180;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

    // Sign-extended, word-scaled branch offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection from JumpOP. PC_ALIGN_CHECK_EN adds the
// misaligned-jr flag output.
module next_pc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  JumpOP,
    input  logic        zero,
    input  logic        is_bne,
    input  logic [15:0] branch_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] rs_data,
`ifdef PC_ALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic [31:0] next_pc
);

    logic [31:0] seq_pc;
    logic        taken;

    assign seq_pc = pc + PC_INC;
    assign taken  = zero ^ is_bne;

    always_comb begin
        next_pc = seq_pc;
        case (JumpOP)
            JOP_SEQ: next_pc = seq_pc;
            JOP_BR:  next_pc = taken ? (seq_pc + branch_offset(branch_imm)) : seq_pc;
            // Low bits are dropped; a misaligned target is redirected upstream when checking is on.
            JOP_JR:  next_pc = {rs_data[31:2], 2'b00};
            JOP_J:   next_pc = {seq_pc[31:28], jump_index, 2'b00};
            default: next_pc = seq_pc;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = (JumpOP == JOP_JR) && (rs_data[1:0] != 2'b00);
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and one-at-a-time instruction fetch FSM (FETCH/WAIT/EXEC).
// Define PC_ALIGN_CHECK_EN to redirect misaligned jr to FAULT_PC with an align_fault pulse.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef PC_ALIGN_CHECK_EN
   ,parameter logic [31:0] FAULT_PC = DEFAULT_FAULT_PC
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   JumpOP,
    input  logic         zero,
    input  logic         is_bne,
    input  logic [15:0]  branch_imm,
    input  logic [25:0]  jump_index,
    input  logic [31:0]  rs_data,
    input  logic         ex_done,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_ready,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr_out,
    output logic         instr_valid,
    output logic [31:0]  pc_out,
    output logic [31:0]  pc_plus4,
`ifdef PC_ALIGN_CHECK_EN
    output logic         align_fault,
`endif
    output fetch_state_t state_dbg
);

    // Handshake: a request transfers on any rising edge where imem_req && imem_ready;
    // imem_req/imem_addr hold steady until then. The response is a single-cycle
    // imem_rvalid no earlier than the cycle after transfer, taken only in WAIT.

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  next_pc;
`ifdef PC_ALIGN_CHECK_EN
    logic         misalign;
`endif

    next_pc_calc u_next_pc_calc (
        .pc         (pc),
        .JumpOP     (JumpOP),
        .zero       (zero),
        .is_bne     (is_bne),
        .branch_imm (branch_imm),
        .jump_index (jump_index),
        .rs_data    (rs_data),
`ifdef PC_ALIGN_CHECK_EN
        .misalign   (misalign),
`endif
        .next_pc    (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr_out   <= 32'd0;
            instr_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            align_fault <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            align_fault <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_out   <= imem_rdata;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (ex_done) begin
                        instr_valid <= 1'b0;
                        state       <= FETCH;
`ifdef PC_ALIGN_CHECK_EN
                        pc          <= misalign ? FAULT_PC : next_pc;
                        align_fault <= misalign;
`else
                        pc          <= next_pc;
`endif
                    end
                end
                default: begin
                    state       <= FETCH;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;
    assign pc_out    = pc;
    assign pc_plus4  = pc + PC_INC;
    assign state_dbg = state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: driver tasks model instruction memory and the
// datapath; a negedge monitor checks fetch addresses and delivered instructions.
module tb_pc_fetch_unit;
    import cpu_pkg::*;

    logic         clk;
    logic         rst;
    logic [1:0]   JumpOP;
    logic         zero;
    logic         is_bne;
    logic [15:0]  branch_imm;
    logic [25:0]  jump_index;
    logic [31:0]  rs_data;
    logic         ex_done;
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr_out;
    logic         instr_valid;
    logic [31:0]  pc_out;
    logic [31:0]  pc_plus4;
    fetch_state_t state_dbg;
`ifdef PC_ALIGN_CHECK_EN
    logic         align_fault;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic [31:0] exp_pc;
    logic        prev_valid;

    pc_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .JumpOP      (JumpOP),
        .zero        (zero),
        .is_bne      (is_bne),
        .branch_imm  (branch_imm),
        .jump_index  (jump_index),
        .rs_data     (rs_data),
        .ex_done     (ex_done),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
`ifdef PC_ALIGN_CHECK_EN
        .align_fault (align_fault),
`endif
        .state_dbg   (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: accepted fetch addresses and newly presented instructions.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (addr_q.size() == 0) begin
                check("fetch_addr_unexpected", imem_addr, 32'hxxxx_xxxx);
            end else begin
                check("fetch_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (!rst && instr_valid && !prev_valid) begin
            if (instr_q.size() == 0) begin
                check("instr_unexpected", instr_out, 32'hxxxx_xxxx);
            end else begin
                check("instr_out", instr_out, instr_q.pop_front());
            end
        end
        prev_valid = rst ? 1'b0 : instr_valid;
    end

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // One full fetch/execute round trip at exp_pc, ending with ex_done.
    task automatic do_instr(input int rdy_dly, input int rv_dly, input bit spurious,
                            input logic [31:0] instr, input logic [1:0] jop,
                            input logic z, input logic bne, input logic [15:0] imm,
                            input logic [25:0] idx, input logic [31:0] rs,
                            input logic [31:0] nxt, input bit fault);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        check("pc_out", pc_out, exp_pc);
        check("pc_plus4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_stable", imem_addr, exp_pc);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
        check("wait_no_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < rv_dly; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = instr;
        instr_q.push_back(instr);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom();
        check("instr_valid_latency", {31'd0, instr_valid}, 32'd1);
        if (spurious) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            tick();
            imem_rvalid = 1'b0;
            check("spurious_ignored", instr_out, instr);
            check("spurious_no_req", {31'd0, imem_req}, 32'd0);
        end
        JumpOP     = jop;
        zero       = z;
        is_bne     = bne;
        branch_imm = imm;
        jump_index = idx;
        rs_data    = rs;
        ex_done    = 1'b1;
        addr_q.push_back(nxt);
        tick();
        ex_done    = 1'b0;
        JumpOP     = 2'($urandom_range(0, 3));
        zero       = 1'($urandom_range(0, 1));
        rs_data    = $urandom();
        exp_pc     = nxt;
        check("valid_cleared", {31'd0, instr_valid}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        check("align_fault", {31'd0, align_fault}, {31'd0, fault});
        tick();
        check("align_fault_pulse_end", {31'd0, align_fault}, 32'd0);
`else
        if (fault) check("no_fault_pc", pc_out, 32'h0000_2000);
`endif
    endtask

    initial begin
        bit ok;
        rst = 1'b1; JumpOP = 2'b00; zero = 1'b0; is_bne = 1'b0;
        branch_imm = 16'd0; jump_index = 26'd0; rs_data = 32'd0; ex_done = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        prev_valid = 1'b0;
        exp_pc = 32'h0000_0000;
        repeat (3) tick();
        check("rst_pc", pc_out, 32'h0000_0000);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, FETCH});
        // Stray ex_done outside EXEC must not move the PC.
        ex_done = 1'b1;
        rst = 1'b0;
        addr_q.push_back(32'h0000_0000);
        tick();
        ex_done = 1'b0;
        check("ex_done_ignored", pc_out, 32'h0000_0000);

        // rdy rv spur instr      jop      z     bne   imm        idx           rs              next           fault
        do_instr(0, 0, 0, 32'h2008_0005, JOP_SEQ, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,          32'h0000_0004, 1'b0);
        do_instr(0, 0, 0, 32'h0800_0010, JOP_J,   1'b0, 1'b0, 16'h0000, 26'h10, 32'h0,         32'h0000_0040, 1'b0);
        do_instr(0, 0, 0, 32'h1000_FFFE, JOP_BR,  1'b1, 1'b0, 16'hFFFE, 26'h0, 32'h0,          32'h0000_003C, 1'b0);
        do_instr(0, 1, 0, 32'h0800_0010, JOP_J,   1'b0, 1'b0, 16'h0000, 26'h10, 32'h0,         32'h0000_0040, 1'b0);
        do_instr(1, 0, 0, 32'h1000_FFFE, JOP_BR,  1'b0, 1'b0, 16'hFFFE, 26'h0, 32'h0,          32'h0000_0044, 1'b0);
        do_instr(0, 0, 0, 32'h0800_0010, JOP_J,   1'b0, 1'b0, 16'h0000, 26'h10, 32'h0,         32'h0000_0040, 1'b0);
        do_instr(3, 2, 1, 32'h1400_FFFE, JOP_BR,  1'b0, 1'b1, 16'hFFFE, 26'h0, 32'h0,          32'h0000_003C, 1'b0);
        do_instr(0, 0, 0, 32'h0060_0008, JOP_JR,  1'b0, 1'b0, 16'h0000, 26'h0, 32'h1000_0008,  32'h1000_0008, 1'b0);
        do_instr(0, 0, 0, 32'h0800_0010, JOP_J,   1'b0, 1'b0, 16'h0000, 26'h10, 32'h0,         32'h1000_0040, 1'b0);
        do_instr(0, 0, 0, 32'h0060_0008, JOP_JR,  1'b1, 1'b0, 16'h0000, 26'h0, 32'h0000_2000,  32'h0000_2000, 1'b0);
        do_instr(0, 0, 0, 32'h0060_0008, JOP_JR,  1'b0, 1'b0, 16'h0000, 26'h0, 32'hFFFF_FFFC,  32'hFFFF_FFFC, 1'b0);
        do_instr(0, 0, 0, 32'h0000_0000, JOP_SEQ, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,          32'h0000_0000, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
        do_instr(0, 0, 0, 32'h0060_0008, JOP_JR,  1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_2002,  32'h0000_0180, 1'b1);
`else
        do_instr(0, 0, 0, 32'h0060_0008, JOP_JR,  1'b0, 1'b0, 16'h0000, 26'h0, 32'h0000_2002,  32'h0000_2000, 1'b1);
`endif

        // Reset while waiting for a response: restart at RESET_PC.
        wait_req(ok);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("mid_wait_state", {30'd0, state_dbg}, {30'd0, WAIT});
        rst = 1'b1;
        tick();
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc", pc_out, 32'h0000_0000);
        rst = 1'b0;
        exp_pc = 32'h0000_0000;
        addr_q.push_back(32'h0000_0000);
        do_instr(0, 0, 0, 32'h2008_0005, JOP_SEQ, 1'b0, 1'b0, 16'h0000, 26'h0, 32'h0,          32'h0000_0004, 1'b0);

        // Final accept drains the last expected address.
        wait_req(ok);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        check("addr_q_drained", addr_q.size(), 32'd0);
        check("instr_q_drained", instr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Downstream consumer of the jump-control stage's 2-bit JumpOP. Holds the architectural PC and computes the next PC from JumpOP, the ALU zero flag, the branch immediate, the jump index and rs. Drives a valid/ready fetch handshake to instruction memory and presents one instruction at a time to decode. Advances only when the datapath signals retirement.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
FAULT_PC, 32'h0000_0180, redirect target on misaligned jr (optional feature only).

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
JumpOP  in  2  00 seq, 01 beq/bne, 10 jr/jalr, 11 j/jal
zero  in  1  ALU zero flag for the current instruction
is_bne  in  1  1 = current branch is bne (opcode bit 0)
branch_imm  in  16  instr[15:0]
jump_index  in  26  instr[25:0]
rs_data  in  32  register rs value for jr/jalr
ex_done  in  1  current instruction retires this cycle
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc_out)
imem_ready  in  1  memory accepts request
imem_rvalid  in  1  response valid
imem_rdata  in  32  response instruction
instr_out  out  32  registered instruction to decode
instr_valid  out  1  instr_out valid, held until ex_done
pc_out  out  32  current PC
pc_plus4  out  32  pc_out + 4, used for jal/jalr link

Behaviour:
- Reset (rst=1 at an edge): pc=RESET_PC, state=FETCH, instr_out=0, instr_valid=0, align_fault=0. imem_req is 0 while rst is high.
- States: FETCH, WAIT, EXEC.
- FETCH: imem_req=1, imem_addr=pc. On imem_req&&imem_ready, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid, latch instr_out=imem_rdata, set instr_valid=1, go to EXEC.
- EXEC: instr_valid=1. On ex_done, pc<=next_pc, instr_valid<=0, go to FETCH.
- Minimum latency: request accepted in cycle N, rvalid in N+1, instr_valid=1 in N+2.
- Memory must not return rvalid in the same cycle as acceptance.
- next_pc, evaluated in the ex_done cycle:
  - 00: pc+4.
  - 01: taken = zero ^ is_bne; taken ? pc+4+(sext(branch_imm)<<2) : pc+4.
  - 10: rs_data.
  - 11: {pc_plus4[31:28], jump_index, 2'b00}.
- All adds are modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- ex_done outside EXEC is ignored.
- imem_rvalid outside WAIT is ignored and dropped.
- JumpOP, zero and the other next-PC inputs are sampled only in the ex_done cycle.
- Reset mid-operation (FETCH/WAIT/EXEC): abandon immediately and restart a fetch at RESET_PC. The instruction memory shares rst, so no stale response arrives.
- Without the optional feature, jr target bits [1:0] are forced to 00.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Adds output align_fault (1 bit, reset 0).
  - When JumpOP=10 and rs_data[1:0]!=0 at ex_done: pc<=FAULT_PC and align_fault pulses high for exactly one cycle (the cycle after ex_done).
- Undefined: no port; jr target is {rs_data[31:2],2'b00}.

Decomposition:
- Shared package cpu_pkg:
  - JumpOP encodings JOP_SEQ=2'b00, JOP_BR=2'b01, JOP_JR=2'b10, JOP_J=2'b11.
  - Fetch state enum FETCH/WAIT/EXEC.
  - Constants PC_INC=32'd4 and default RESET_PC/FAULT_PC.
- One combinational sub-module, next_pc_calc: inputs pc, JumpOP, zero, is_bne, branch_imm, jump_index, rs_data; outputs next_pc (and a misalign flag). Instantiated once; the FSM stays in pc_fetch_unit.

Test Plan:
- Reset then release; memory ready=1, returns 32'h2008_0005 one cycle later -> imem_addr=0, instr_valid at cycle 2, instr_out=32'h2008_0005; ex_done with JumpOP=00 -> next imem_addr=4.
- pc=0x40, JumpOP=01, is_bne=0, zero=1, imm=16'hFFFE -> next pc=0x3C. Same with zero=0 -> 0x44. is_bne=1, zero=0 -> 0x3C.
- pc=0x1000_0008, JumpOP=11, jump_index=26'h000_0010 -> next pc=0x1000_0040. JumpOP=10, rs_data=0x0000_2000 -> next pc=0x2000.
- imem_ready low for 3 cycles, then rvalid delayed 2 cycles -> imem_req stays high and address stable; one instruction only; spurious rvalid in EXEC ignored.
- pc=0xFFFF_FFFC, JumpOP=00 -> pc=0. rst asserted in WAIT -> next request at RESET_PC, instr_valid=0.
- With PC_ALIGN_CHECK_EN, JumpOP=10, rs_data=0x0000_2002 -> pc=0x180, align_fault one-cycle pulse. Without the macro -> pc=0x2000.
